// File: rtl/adi_regmap_bank.sv
// Parametrised up_* register bank: per-bit RW / RO / RW1C / RW1S behaviour,
// same-cycle software/hardware arbitration and a registered RW1C interrupt.

module adi_regmap_bank_reg #(
   parameter int            DW   = 32,
   parameter logic [DW-1:0] M_RW = '0,
   parameter logic [DW-1:0] M_C  = '0,
   parameter logic [DW-1:0] M_S  = '0,
   parameter logic [DW-1:0] RST  = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [DW-1:0] wdata,
   input  logic [DW-1:0] hw_set,
   input  logic [DW-1:0] hw_clr,
   output logic [DW-1:0] q
);
   logic [DW-1:0] wr1, nxt;

   // hw_set beats a software clear on RW1C; a software set beats hw_clr on RW1S
   always_comb begin
      wr1 = we ? wdata : '0;
      nxt = (M_C  & (hw_set | (q & ~wr1)))
          | (M_S  & (wr1 | (q & ~hw_clr)))
          | (M_RW & (we ? wdata : q));
   end

   always_ff @(posedge clk) begin
      if (reset) q <= RST & (M_RW | M_C | M_S);
      else       q <= nxt;
   end
endmodule

module adi_regmap_bank #(
   parameter int NUM_REGS   = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int BASE_ADDR  = 0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW1C_MASK   = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW1S_MASK   = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RO_MASK     = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] IRQ_EN_MASK = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           up_wreq,
   input  logic [ADDR_WIDTH-1:0]          up_waddr,
   input  logic [DATA_WIDTH-1:0]          up_wdata,
   output logic                           up_wack,
   input  logic                           up_rreq,
   input  logic [ADDR_WIDTH-1:0]          up_raddr,
   output logic [DATA_WIDTH-1:0]          up_rdata,
   output logic                           up_rack,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_clr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic                           irq
);
   localparam int W = NUM_REGS*DATA_WIDTH;
   // Resolve overlaps once: RW1C > RW1S > RO > RW
   localparam logic [W-1:0] C_M  = RW1C_MASK;
   localparam logic [W-1:0] S_M  = RW1S_MASK & ~C_M;
   localparam logic [W-1:0] RO_M = RO_MASK & ~C_M & ~S_M;
   localparam logic [W-1:0] RW_M = RW_MASK & ~C_M & ~S_M & ~RO_M;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [31:0]           NR   = NUM_REGS;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] q_arr, st_arr, set_arr, clr_arr, ro_arr;
   logic [NUM_REGS-1:0]                 we_arr;
   logic [ADDR_WIDTH-1:0]               woff, roff;
   logic                                whit, rhit;
   logic [DATA_WIDTH-1:0]               rd_val, rdata_q;
   logic                                wack_q, rack_q, irq_q;

   assign st_arr  = hw_status;
   assign set_arr = hw_set;
   assign clr_arr = hw_clr;
   assign ro_arr  = RO_M;

   assign woff = up_waddr - BASE;
   assign roff = up_raddr - BASE;
   assign whit = (up_waddr >= BASE) && (32'(woff) < NR);
   assign rhit = (up_raddr >= BASE) && (32'(roff) < NR);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [31:0] IDX = i;
      assign we_arr[i] = up_wreq & whit & (32'(woff) == IDX);
      adi_regmap_bank_reg #(
         .DW   (DATA_WIDTH),
         .M_RW (RW_M[i*DATA_WIDTH +: DATA_WIDTH]),
         .M_C  (C_M[i*DATA_WIDTH +: DATA_WIDTH]),
         .M_S  (S_M[i*DATA_WIDTH +: DATA_WIDTH]),
         .RST  (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH])
      ) u_reg (
         .clk    (clk),
         .reset  (reset),
         .we     (we_arr[i]),
         .wdata  (up_wdata),
         .hw_set (set_arr[i]),
         .hw_clr (clr_arr[i]),
         .q      (q_arr[i])
      );
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rhit && (32'(roff) == $unsigned(i)))
            rd_val = q_arr[i] | (st_arr[i] & ro_arr[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wack_q  <= 1'b0;
         rack_q  <= 1'b0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         wack_q  <= up_wreq;
         rack_q  <= up_rreq;
         rdata_q <= up_rreq ? rd_val : '0;
         irq_q   <= |(q_arr & C_M & IRQ_EN_MASK);
      end
   end

   // Acks are masked while reset is high so a request one cycle before reset is dropped
   assign up_wack  = wack_q & ~reset;
   assign up_rack  = rack_q & ~reset;
   assign up_rdata = up_rack ? rdata_q : '0;
   assign reg_out  = q_arr;
   assign irq      = irq_q;
endmodule
